// File: rtl/word_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_serializer_pkg : shared states and defaults for word_serializer      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package word_serializer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5,
      ST_GAP    = 3'd6
   } state_e;

   // start + 8 data + parity + stop
   localparam int CHAR_BITS = 11;

   localparam int DEF_CLK_DIV    = 16;
   localparam int DEF_SAMPLE_DLY = 40;
   localparam int DEF_WORDS      = 128;
   localparam int DEF_GAP_BITS   = 2;

endpackage
`default_nettype wire

// File: rtl/word_serializer_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_serializer_bit_timer : CLK_DIV prescaler with restart and tick       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module word_serializer_bit_timer #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign tick = (cnt_q == DIV_LAST);

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_serializer : paces commutator slots and sends each byte as 8-O-1     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int SAMPLE_DLY = DEF_SAMPLE_DLY,
   parameter int WORDS      = DEF_WORDS,
   parameter int GAP_BITS   = DEF_GAP_BITS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] dataIn,
   output logic       req,
   output logic       txd,
   output logic       frameStart,
   output logic       busy
);

   localparam int             WCW       = (WORDS > 2) ? $clog2(WORDS) : 1;
   localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS - 1);
   localparam logic [7:0]     DLY_LAST  = 8'(SAMPLE_DLY - 1);
   localparam logic [3:0]     GAP_LAST  = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

   state_e         state_q, state_d;
   logic [7:0]     dly_q, dly_d;
   logic [7:0]     shreg_q, shreg_d;
   logic           par_q, par_d;
   logic [2:0]     bit_q, bit_d;
   logic [3:0]     gap_q, gap_d;
   logic [WCW-1:0] word_q, word_d;
   logic           req_q, req_d;
   logic           txd_q, txd_d;
   logic           frame_start_q, frame_start_d;
   logic           busy_q, busy_d;

   logic           tick;
   logic           restart;
   logic           end_word;
   logic [WCW-1:0] word_inc;

   // Bit periods are timed from each state entry so a frame cannot drift.
   assign restart  = (state_d != state_q);
   assign word_inc = (word_q == WORD_LAST) ? '0 : word_q + WCW'(1);

   word_serializer_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      state_d       = state_q;
      dly_d         = '0;
      shreg_d       = shreg_q;
      par_d         = par_q;
      bit_d         = bit_q;
      gap_d         = gap_q;
      word_d        = word_q;
      req_d         = req_q;
      txd_d         = txd_q;
      frame_start_d = 1'b0;
      end_word      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            word_d = '0;
            if (en) begin
               state_d       = ST_REQ;
               req_d         = 1'b1;
               frame_start_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (dly_q == DLY_LAST) begin
               shreg_d = dataIn;
               par_d   = ~^dataIn;
               req_d   = 1'b0;
               txd_d   = 1'b0;
               state_d = ST_START;
            end else begin
               dly_d = dly_q + 8'd1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = '0;
               txd_d   = shreg_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  state_d = ST_PARITY;
                  txd_d   = par_q;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  txd_d   = shreg_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (GAP_BITS == 0) begin
                  end_word = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  gap_d   = '0;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               if (gap_q == GAP_LAST) begin
                  end_word = 1'b1;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            txd_d   = 1'b1;
         end
      endcase

      if (end_word) begin
         if (en) begin
            state_d       = ST_REQ;
            req_d         = 1'b1;
            word_d        = word_inc;
            frame_start_d = (word_inc == '0);
         end else begin
            state_d = ST_IDLE;
            word_d  = '0;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         dly_q         <= '0;
         shreg_q       <= '0;
         par_q         <= 1'b0;
         bit_q         <= '0;
         gap_q         <= '0;
         word_q        <= '0;
         req_q         <= 1'b0;
         txd_q         <= 1'b1;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         dly_q         <= dly_d;
         shreg_q       <= shreg_d;
         par_q         <= par_d;
         bit_q         <= bit_d;
         gap_q         <= gap_d;
         word_q        <= word_d;
         req_q         <= req_d;
         txd_q         <= txd_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
      end
   end

   assign req        = req_q;
   assign txd        = txd_q;
   assign frameStart = frame_start_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire

// File: doc/word_serializer.md
# word_serializer

Downstream transmit stage for the commutator. It paces one frame of `WORDS` byte slots. For each slot it raises `req`, waits a fixed settle time, and latches the commutator's `dataTx`. It then shifts the byte out on `txd` as an asynchronous serial character: start bit, 8 data bits LSB first, odd parity, stop bit. It sits between the commutator and the line driver, and it is the sole source of the commutator's `req`.

## Interface
- `CLK_DIV`, 16: clk cycles per serial bit; legal range 2..255.
- `SAMPLE_DLY`, 40: clk cycles `req` stays high before `dataIn` is latched; must be ≥ 36 to cover commutator sync plus pause; legal range 1..255.
- `WORDS`, 128: byte slots per frame; legal range 2..256.
- `GAP_BITS`, 2: idle-high bit periods after each stop bit; legal range 0..15.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: level enable; frames run back-to-back while high.
- `dataIn` in 8: byte from commutator `dataTx`.
- `req` out 1: slot request to commutator `req`.
- `txd` out 1: serial line; idle high.
- `frameStart` out 1: one-cycle pulse on the `req` rise of word 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- Reset values: state IDLE, `req`=0, `txd`=1, `frameStart`=0, `busy`=0. All counters and the shift register clear to 0.
- All outputs are registered.
- IDLE:
  - `en`=1 moves to REQ and sets `req`=1.
  - On this entry the word counter is 0, so `frameStart` pulses.
- REQ:
  - `req` is held high; the delay counter counts 0..SAMPLE_DLY-1.
  - On the last count: latch `dataIn` into the shift register, compute odd parity (~^data), drop `req`, set `txd`=0, and go to START.
- START: `txd`=0 for CLK_DIV cycles, then DATA.
- DATA:
  - 8 bits, LSB first, CLK_DIV cycles each.
  - A bit counter runs 0..7; the shift register shifts right.
- PARITY: one bit period carrying the odd-parity bit (total count of ones in data plus parity is odd).
- STOP: `txd`=1 for one bit period.
- GAP:
  - `txd`=1 for GAP_BITS bit periods.
  - GAP_BITS=0 skips this state.
- End of word:
  - If word counter = WORDS-1, the counter wraps to 0. Otherwise it increments.
  - If `en`=1, go to REQ (with `frameStart` if the counter is now 0). If `en`=0, go to IDLE.
- `en` falling mid-word: the current word completes in full. The word counter clears to 0 on entry to IDLE, so a re-enable always starts a fresh frame.
- `dataIn` is sampled only at the latch cycle; changes at any other time are ignored.
- Asynchronous reset mid-character: `txd` returns to 1 and `req` to 0 immediately. No partial character is resumed.

## Timing
- Word period = SAMPLE_DLY + (11 + GAP_BITS) × CLK_DIV cycles. Defaults: 40 + 13×16 = 248.
- `req` high time = exactly SAMPLE_DLY cycles.
- `req` low time = (11 + GAP_BITS) × CLK_DIV cycles. This must exceed 2 cycles so the commutator's WAIT→IDLE return is seen.
- Latency from the `req` rise to the falling edge of the start bit on `txd` = SAMPLE_DLY cycles.
- Frame period = WORDS × word period. Defaults: 31744 cycles.
- `frameStart` is coincident with the first cycle of `req`=1 for word 0.
- The bit-period counter restarts at every state change, so there is no drift across a frame.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, START, DATA, PARITY, STOP, GAP);
  - the character-length constant 11;
  - the default parameter values, shared with the commutator testbench.
- Natural sub-module: `bit_timer`, a CLK_DIV prescaler with a restart input and a one-cycle `tick` output.
- Everything else stays in one always block plus the output registers.

## Test plan
- Reset then `en`=1, `dataIn`=8'hA5:
  - `req` high 40 cycles.
  - `txd` = 0, 1,0,1,0,0,1,0,1, parity 1, stop 1, 2 idle bits, 16 cycles each.
  - Next `req` rise at cycle 248.
- `dataIn`=8'h00 then 8'hFF on consecutive words: parity bits are 1 and 1 respectively.
- Run a full frame with defaults: `frameStart` pulses exactly once per 31744 cycles; 128 `req` rises between pulses.
- Drop `en` during DATA bit 3 of word 5:
  - The word finishes, including gap.
  - `busy` goes to 0 and no further `req`.
  - On re-enable, `frameStart` fires on the first `req`.
- Assert `rst` low mid-PARITY: `txd`=1 and `req`=0 in the same cycle; after release, idle until `en`.
- Connect to the commutator with a temp-memory model: the latched byte equals the commutator's `dataTx` at cycle SAMPLE_DLY-1 after the `req` rise for all 128 slots.
